// File: rtl/proc_control_unit.sv
// Control unit for the 16-bit processor: PC, IR, sequencing FSM and Moore-decoded datapath strobes.
// Optional macro PROC_STEP_EN gates each Fetch on the Step input for single-stepping.
module proc_control_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Step,
    input  logic [15:0] I_Data,
    output logic [4:0]  PC_Out,
    output logic [15:0] IR_Out,
    output logic [3:0]  StateO,
    output logic [7:0]  D_Addr,
    output logic        D_Wr,
    output logic        RF_s,
    output logic [3:0]  RF_W_Addr,
    output logic        RF_W_en,
    output logic [3:0]  RF_Ra_Addr,
    output logic [3:0]  RF_Rb_Addr,
    output logic [2:0]  ALU_s0
);
    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_NOOP   = 4'd3;
    localparam logic [3:0] S_LOADA  = 4'd4;
    localparam logic [3:0] S_LOADB  = 4'd5;
    localparam logic [3:0] S_STORE  = 4'd6;
    localparam logic [3:0] S_ADD    = 4'd7;
    localparam logic [3:0] S_SUB    = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;

    logic [3:0]  r_state;
    logic [3:0]  w_next;
    logic [4:0]  r_pc;
    logic [15:0] r_ir;
    logic        w_advance;

`ifdef PROC_STEP_EN
    assign w_advance = Step;
`else
    // Step is a don't-care here; OR-ing with 1 keeps the port referenced.
    assign w_advance = Step | 1'b1;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_INIT;
            r_pc    <= 5'd0;
            r_ir    <= 16'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_INIT) begin
                r_pc <= 5'd0;
                r_ir <= 16'd0;
            end else if (r_state == S_FETCH && w_advance) begin
                r_ir <= I_Data;
                r_pc <= r_pc + 5'd1;
            end
        end
    end

    always_comb begin
        w_next = S_INIT;
        case (r_state)
            S_INIT:   w_next = S_FETCH;
            S_FETCH:  w_next = w_advance ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (r_ir[15:12])
                    4'h1:    w_next = S_STORE;
                    4'h2:    w_next = S_LOADA;
                    4'h3:    w_next = S_ADD;
                    4'h4:    w_next = S_SUB;
                    4'h5:    w_next = S_HALT;
                    default: w_next = S_NOOP;
                endcase
            end
            S_NOOP, S_LOADB, S_STORE, S_ADD, S_SUB: w_next = S_FETCH;
            S_LOADA:  w_next = S_LOADB;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_INIT;
        endcase
    end

    always_comb begin
        D_Addr     = 8'd0;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_Addr  = 4'd0;
        RF_W_en    = 1'b0;
        RF_Ra_Addr = 4'd0;
        RF_Rb_Addr = 4'd0;
        ALU_s0     = 3'b000;
        case (r_state)
            S_LOADA: D_Addr = r_ir[11:4];
            S_LOADB: begin
                D_Addr    = r_ir[11:4];
                RF_s      = 1'b1;
                RF_W_Addr = r_ir[3:0];
                RF_W_en   = 1'b1;
            end
            S_STORE: begin
                D_Addr     = r_ir[11:4];
                RF_Ra_Addr = r_ir[3:0];
                D_Wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Ra_Addr = r_ir[11:8];
                RF_Rb_Addr = r_ir[7:4];
                RF_W_Addr  = r_ir[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = (r_state == S_ADD) ? 3'b001 : 3'b010;
            end
            default: ;
        endcase
    end

    assign PC_Out = r_pc;
    assign IR_Out = r_ir;
    assign StateO = r_state;
endmodule

// File: tb/tb_proc_control_unit.sv
// Directed bench for proc_control_unit: ROM model driven from PC_Out, per-cycle checks on state, PC and strobes.
module tb_proc_control_unit;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        Step;
    logic [15:0] I_Data;
    logic [4:0]  PC_Out;
    logic [15:0] IR_Out;
    logic [3:0]  StateO;
    logic [7:0]  D_Addr;
    logic        D_Wr, RF_s, RF_W_en;
    logic [3:0]  RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr;
    logic [2:0]  ALU_s0;

    logic [15:0] rom [32];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;
    assign I_Data = rom[PC_Out];

    proc_control_unit dut (
        .Clk(Clk), .Reset(Reset), .Step(Step), .I_Data(I_Data),
        .PC_Out(PC_Out), .IR_Out(IR_Out), .StateO(StateO),
        .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s), .RF_W_Addr(RF_W_Addr),
        .RF_W_en(RF_W_en), .RF_Ra_Addr(RF_Ra_Addr), .RF_Rb_Addr(RF_Rb_Addr),
        .ALU_s0(ALU_s0)
    );

    // All strobes/addresses flattened: {D_Addr, D_Wr, RF_s, W_Addr, W_en, Ra, Rb, ALU}
    logic [25:0] outs;
    assign outs = {D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en, RF_Ra_Addr, RF_Rb_Addr, ALU_s0};

    function automatic logic [25:0] eo(input logic [7:0] da, input logic dw, input logic s,
                                       input logic [3:0] wa, input logic we, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [2:0] alu);
        return {da, dw, s, wa, we, ra, rb, alu};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic look(input string tag, input logic [3:0] st, input logic [4:0] pc, input logic [25:0] o);
        chk({tag, ".state"}, {28'd0, StateO}, {28'd0, st});
        chk({tag, ".pc"}, {27'd0, PC_Out}, {27'd0, pc});
        chk({tag, ".outs"}, {6'd0, outs}, {6'd0, o});
    endtask

    task automatic nxt(input string tag, input logic [3:0] st, input logic [4:0] pc, input logic [25:0] o);
        tick();
        look(tag, st, pc, o);
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        look({tag, ".init"}, 4'd0, 5'd0, 26'd0);
        chk({tag, ".init_ir"}, {16'd0, IR_Out}, 32'd0);
    endtask

    task automatic clr_rom;
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    endtask

    initial begin
        Reset = 1'b1;
`ifdef PROC_STEP_EN
        Step = 1'b1;
`else
        Step = 1'b0;
`endif
        clr_rom();
        @(negedge Clk);

        // All-NOOP ROM: 1,2,3 loop, PC advances once per Fetch, no strobes
        do_reset("noop");
        nxt("noop.f0", 4'd1, 5'd0, 26'd0);
        nxt("noop.d0", 4'd2, 5'd1, 26'd0);
        nxt("noop.n0", 4'd3, 5'd1, 26'd0);
        nxt("noop.f1", 4'd1, 5'd1, 26'd0);
        nxt("noop.d1", 4'd2, 5'd2, 26'd0);
        nxt("noop.n1", 4'd3, 5'd2, 26'd0);

        // LOAD D[0x1B] -> R3, then HALT
        clr_rom();
        rom[0] = 16'h21B3; rom[1] = 16'h5000;
        do_reset("load");
        nxt("load.f", 4'd1, 5'd0, 26'd0);
        nxt("load.d", 4'd2, 5'd1, 26'd0);
        chk("load.ir", {16'd0, IR_Out}, 32'h21B3);
        nxt("load.a", 4'd4, 5'd1, eo(8'h1B, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'd0));
        nxt("load.b", 4'd5, 5'd1, eo(8'h1B, 0, 1, 4'd3, 1, 4'd0, 4'd0, 3'd0));
        nxt("load.f2", 4'd1, 5'd1, 26'd0);
        nxt("load.d2", 4'd2, 5'd2, 26'd0);
        nxt("halt.0", 4'd9, 5'd2, 26'd0);
        nxt("halt.1", 4'd9, 5'd2, 26'd0);
        nxt("halt.2", 4'd9, 5'd2, 26'd0);
        chk("halt.ir", {16'd0, IR_Out}, 32'h5000);

        // ADD R4<-R1+R2, SUB R5<-R4-R1, HALT (reset also leaves Halt)
        clr_rom();
        rom[0] = 16'h3124; rom[1] = 16'h4415; rom[2] = 16'h5000;
        do_reset("arith");
        nxt("add.f", 4'd1, 5'd0, 26'd0);
        nxt("add.d", 4'd2, 5'd1, 26'd0);
        nxt("add.x", 4'd7, 5'd1, eo(8'h00, 0, 0, 4'd4, 1, 4'd1, 4'd2, 3'b001));
        nxt("sub.f", 4'd1, 5'd1, 26'd0);
        nxt("sub.d", 4'd2, 5'd2, 26'd0);
        nxt("sub.x", 4'd8, 5'd2, eo(8'h00, 0, 0, 4'd5, 1, 4'd4, 4'd1, 3'b010));
        nxt("arith.f", 4'd1, 5'd2, 26'd0);

        // STORE R6 -> D[0x80], then reserved opcode E123 takes NoOp path
        clr_rom();
        rom[0] = 16'h1806; rom[1] = 16'hE123; rom[2] = 16'h5000;
        do_reset("store");
        nxt("store.f", 4'd1, 5'd0, 26'd0);
        nxt("store.d", 4'd2, 5'd1, 26'd0);
        nxt("store.x", 4'd6, 5'd1, eo(8'h80, 1, 0, 4'd0, 0, 4'd6, 4'd0, 3'd0));
        nxt("resv.f", 4'd1, 5'd1, 26'd0);
        nxt("resv.d", 4'd2, 5'd2, 26'd0);
        nxt("resv.n", 4'd3, 5'd2, 26'd0);
        chk("resv.ir", {16'd0, IR_Out}, 32'hE123);
        nxt("resv.f2", 4'd1, 5'd2, 26'd0);

        // 31 NOOPs then fetch of address 31 wraps PC to 0
        clr_rom();
        do_reset("wrap");
        nxt("wrap.f0", 4'd1, 5'd0, 26'd0);
        for (int i = 0; i < 93; i++) tick();
        look("wrap.f31", 4'd1, 5'd31, 26'd0);
        nxt("wrap.d31", 4'd2, 5'd0, 26'd0);
        nxt("wrap.n31", 4'd3, 5'd0, 26'd0);
        nxt("wrap.f0b", 4'd1, 5'd0, 26'd0);

        // Reset during LoadA aborts the LOAD: no RF write ever seen
        clr_rom();
        rom[0] = 16'h21B3;
        do_reset("abort");
        nxt("abort.f", 4'd1, 5'd0, 26'd0);
        nxt("abort.d", 4'd2, 5'd1, 26'd0);
        nxt("abort.a", 4'd4, 5'd1, eo(8'h1B, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'd0));
        do_reset("abort.rst");
        nxt("abort.f2", 4'd1, 5'd0, 26'd0);

`ifdef PROC_STEP_EN
        // Fetch holds without Step; a one-cycle pulse runs exactly one instruction
        clr_rom();
        Step = 1'b0;
        do_reset("step");
        for (int i = 0; i < 10; i++) nxt("step.hold", 4'd1, 5'd0, 26'd0);
        Step = 1'b1;
        nxt("step.d", 4'd2, 5'd1, 26'd0);
        Step = 1'b0;
        nxt("step.n", 4'd3, 5'd1, 26'd0);
        nxt("step.f", 4'd1, 5'd1, 26'd0);
        nxt("step.hold2", 4'd1, 5'd1, 26'd0);
        Step = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
